// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
// A fetch entry pairs a returned instruction word with the PC it was read from.
package if_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0]      HLT_OPCODE_DEF = 4'hF;
    localparam logic [PC_W-1:0] RESET_PC_DEF   = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic is_opcode(input logic [INSTR_W-1:0] word,
                                       input logic [3:0]         opc);
        return word[OPC_MSB:OPC_LSB] == opc;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries with push, pop and a flush that
// empties it in one edge. Flush has priority over push and pop.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_data,
    output fetch_entry_t               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one memory read per cycle when there is
// room, buffers returned words and hands them to decode; supports redirect and halt.
module instr_fetch
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              DEPTH      = 2,
    parameter logic [3:0]      HLT_OPCODE = HLT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    im_addr,
    output logic               im_rd_en,
    input  logic [INSTR_W-1:0] im_instr,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid,
    input  logic               id_ready,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_tgt,
    output logic               halted
);

    logic [PC_W-1:0]        pc_q, pc_d;
    logic                   halted_q, halted_d;
    logic                   issue;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;

    // Decode handshake: an entry moves when if_valid & id_ready are both high at a
    // rising edge; a redirect in the same cycle cancels the transfer.
    assign pop   = if_valid & id_ready & ~branch_taken;
    assign issue = ~rst & ~halted_q & ~branch_taken & (~fifo_full | pop);

    assign im_addr  = pc_q;
    assign im_rd_en = issue;
    assign halted   = halted_q;

    assign push_entry = '{instr: im_instr, pc: pc_q};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .pop     (pop),
        .flush   (branch_taken),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign if_valid = ~fifo_empty;
    assign if_instr = if_valid ? head_entry.instr : '0;
    assign if_pc    = if_valid ? head_entry.pc    : '0;

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (branch_taken) begin
            pc_d     = branch_tgt;
            halted_d = 1'b0;
        end else if (issue) begin
            pc_d = pc_q + PC_W'(1);
            if (is_opcode(im_instr, HLT_OPCODE)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(fifo_count) <= DEPTH);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a behavioural instruction memory answers reads,
// and each task checks one scenario against hand-computed values.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        rst = 1'b1;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr = 16'h0000;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        id_ready = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_tgt = 16'h0000;
    logic        halted;

    // Wrap DUT (RESET_PC = FFFE)
    logic        rst2 = 1'b1;
    logic [15:0] im_addr2;
    logic        im_rd_en2;
    logic [15:0] im_instr2 = 16'h0000;
    logic [15:0] if_instr2;
    logic [15:0] if_pc2;
    logic        if_valid2;
    logic        halted2;

    int          errors = 0;
    int          checks = 0;
    logic        hlt_en = 1'b0;
    logic [15:0] exp_q[$];

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .im_addr      (im_addr),
        .im_rd_en     (im_rd_en),
        .im_instr     (im_instr),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .id_ready     (id_ready),
        .branch_taken (branch_taken),
        .branch_tgt   (branch_tgt),
        .halted       (halted)
    );

    instr_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk          (clk),
        .rst          (rst2),
        .im_addr      (im_addr2),
        .im_rd_en     (im_rd_en2),
        .im_instr     (im_instr2),
        .if_instr     (if_instr2),
        .if_pc        (if_pc2),
        .if_valid     (if_valid2),
        .id_ready     (1'b1),
        .branch_taken (1'b0),
        .branch_tgt   (16'h0000),
        .halted       (halted2)
    );

    // Memory image: word at addr a is {1, a[11:0]}; optionally addr 2 holds HLT.
    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic hlt);
        if (hlt && a == 16'd2) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    // Memory latches the request on clk low; data is stable by the next rising edge.
    always @(negedge clk) begin
        if (im_rd_en) im_instr = mem_word(im_addr, hlt_en);
        if (im_rd_en2) im_instr2 = mem_word(im_addr2, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_ready = 1'b1;
        branch_taken = 1'b0;
        branch_tgt = 16'h0000;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_ready = 1'b1;
        branch_taken = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", if_instr); end
        checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", if_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", im_rd_en); end
        checks++; if (im_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", im_addr); end
        rst = 1'b0;
        #1;
        checks++; if (im_rd_en !== 1'b1) begin errors++; $display("FAIL release_rd_en: got %b want 1", im_rd_en); end
        checks++; if (im_addr !== 16'h0000) begin errors++; $display("FAIL release_addr: got %h want 0000", im_addr); end
    endtask

    task automatic test_straight();
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL straight_valid c=%0d: got %b want 1", i + 1, if_valid); end
            checks++; if (if_pc !== 16'(i)) begin errors++; $display("FAIL straight_pc c=%0d: got %h want %h", i + 1, if_pc, 16'(i)); end
            checks++; if (if_instr !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL straight_instr c=%0d: got %h want %h", i + 1, if_instr, 16'h1000 + 16'(i)); end
            checks++; if (im_rd_en !== 1'b1) begin errors++; $display("FAIL straight_rd_en c=%0d: got %b want 1", i + 1, im_rd_en); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] e;
        do_reset();
        exp_q = {};
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
        for (int c = 1; c <= 12; c++) begin
            tick();
            id_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
            #1;
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d: got %b want 1", c, if_valid); end
            if (c >= 4 && c <= 7) begin
                checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en c=%0d: got %b want 0", c, im_rd_en); end
                checks++; if (im_addr !== 16'h0004) begin errors++; $display("FAIL stall_addr c=%0d: got %h want 0004", c, im_addr); end
                checks++; if (if_pc !== 16'h0002) begin errors++; $display("FAIL stall_head c=%0d: got %h want 0002", c, if_pc); end
            end
            if (if_valid === 1'b1 && id_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                checks++; if (if_pc !== e) begin errors++; $display("FAIL stall_seq_pc c=%0d: got %h want %h", c, if_pc, e); end
                checks++; if (if_instr !== {4'h1, e[11:0]}) begin errors++; $display("FAIL stall_seq_instr c=%0d: got %h want %h", c, if_instr, {4'h1, e[11:0]}); end
            end
        end
        checks++; if (exp_q.size() !== 3) begin errors++; $display("FAIL stall_accept_count: got %0d left want 3", exp_q.size()); end
        id_ready = 1'b1;
    endtask

    task automatic test_redirect();
        logic [15:0] e;
        do_reset();
        exp_q = {16'h0000, 16'h0001, 16'h0002, 16'h0040, 16'h0041};
        for (int c = 1; c <= 8; c++) begin
            tick();
            id_ready = (c == 4) ? 1'b0 : 1'b1;
            branch_taken = (c == 5);
            branch_tgt = 16'h0040;
            #1;
            if (c == 5) begin
                checks++; if (if_pc !== 16'h0003) begin errors++; $display("FAIL redir_head: got %h want 0003", if_pc); end
                checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL redir_rd_en: got %b want 0", im_rd_en); end
            end
            if (c == 6) begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b want 0", if_valid); end
                checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL redir_flush_pc: got %h want 0000", if_pc); end
                checks++; if (if_instr !== 16'h0000) begin errors++; $display("FAIL redir_flush_instr: got %h want 0000", if_instr); end
                checks++; if (im_addr !== 16'h0040) begin errors++; $display("FAIL redir_addr: got %h want 0040", im_addr); end
                checks++; if (im_rd_en !== 1'b1) begin errors++; $display("FAIL redir_tgt_rd_en: got %b want 1", im_rd_en); end
            end
            if (c == 7) begin
                checks++; if (if_instr !== 16'h1040) begin errors++; $display("FAIL redir_tgt_instr: got %h want 1040", if_instr); end
            end
            if (if_valid === 1'b1 && id_ready && !branch_taken) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                checks++; if (if_pc !== e) begin errors++; $display("FAIL redir_seq c=%0d: got %h want %h", c, if_pc, e); end
            end
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL redir_accept_count: got %0d left want 0", exp_q.size()); end
        branch_taken = 1'b0;
    endtask

    task automatic test_hlt();
        hlt_en = 1'b1;
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            tick();
            branch_taken = (c == 5);
            branch_tgt = 16'h0010;
            #1;
            if (c == 2) begin
                checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_early: got %b want 0", halted); end
            end
            if (c == 3) begin
                checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_set: got %b want 1", halted); end
                checks++; if (if_pc !== 16'h0002) begin errors++; $display("FAIL hlt_pc: got %h want 0002", if_pc); end
                checks++; if (if_instr !== 16'hF000) begin errors++; $display("FAIL hlt_instr: got %h want F000", if_instr); end
                checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL hlt_rd_en: got %b want 0", im_rd_en); end
                checks++; if (im_addr !== 16'h0003) begin errors++; $display("FAIL hlt_addr: got %h want 0003", im_addr); end
            end
            if (c == 4 || c == 5) begin
                checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_hold c=%0d: got %b want 1", c, halted); end
                checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL hlt_idle c=%0d: got %b want 0", c, im_rd_en); end
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hlt_drained c=%0d: got %b want 0", c, if_valid); end
            end
            if (c == 6) begin
                checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_resume: got %b want 0", halted); end
                checks++; if (im_rd_en !== 1'b1) begin errors++; $display("FAIL hlt_resume_rd_en: got %b want 1", im_rd_en); end
                checks++; if (im_addr !== 16'h0010) begin errors++; $display("FAIL hlt_resume_addr: got %h want 0010", im_addr); end
            end
            if (c == 7) begin
                checks++; if (if_pc !== 16'h0010) begin errors++; $display("FAIL hlt_resume_pc: got %h want 0010", if_pc); end
                checks++; if (if_instr !== 16'h1010) begin errors++; $display("FAIL hlt_resume_instr: got %h want 1010", if_instr); end
            end
        end
        branch_taken = 1'b0;
        hlt_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] pcs [4];
        logic [15:0] ins [4];
        pcs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        ins = '{16'h1FFE, 16'h1FFF, 16'h1000, 16'h1001};
        tick();
        checks++; if (im_addr2 !== 16'hFFFE) begin errors++; $display("FAIL wrap_reset_addr: got %h want FFFE", im_addr2); end
        checks++; if (im_rd_en2 !== 1'b0) begin errors++; $display("FAIL wrap_reset_rd_en: got %b want 0", im_rd_en2); end
        rst2 = 1'b0;
        #1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            #1;
            checks++; if (if_pc2 !== pcs[c-1]) begin errors++; $display("FAIL wrap_pc c=%0d: got %h want %h", c, if_pc2, pcs[c-1]); end
            checks++; if (if_instr2 !== ins[c-1]) begin errors++; $display("FAIL wrap_instr c=%0d: got %h want %h", c, if_instr2, ins[c-1]); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            tick();
            id_ready = (c >= 3) ? 1'b1 : 1'b0;
            rst = (c == 2);
            #1;
            if (c == 2) begin
                checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en_in_rst: got %b want 0", im_rd_en); end
                checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL midrst_full_before: got %b want 1", if_valid); end
            end
            if (c == 3) begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", if_valid); end
                checks++; if (halted !== 1'b0) begin errors++; $display("FAIL midrst_halted: got %b want 0", halted); end
                checks++; if (im_addr !== 16'h0000) begin errors++; $display("FAIL midrst_addr: got %h want 0000", im_addr); end
                checks++; if (im_rd_en !== 1'b1) begin errors++; $display("FAIL midrst_rd_en_after: got %b want 1", im_rd_en); end
                checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL midrst_pc: got %h want 0000", if_pc); end
            end
            if (c == 4) begin
                checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL midrst_first_pc: got %h want 0000", if_pc); end
                checks++; if (if_instr !== 16'h1000) begin errors++; $display("FAIL midrst_first_instr: got %h want 1000", if_instr); end
            end
        end
        rst = 1'b0;
        id_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_hlt();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
